asic_cellbist: RTL and testbench



---
 rtl/asic_cellbist_pkg.sv | 16 +
 rtl/asic_cellbist_if.sv | 29 ++
 rtl/asic_cellbist.sv | 110 +++++++++++
 tb/tb_asic_cellbist.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/asic_cellbist_pkg.sv
// Shared types for the cell BIST sequencer family.
// State encoding is reused by future multi-output cell BIST blocks.
package asic_cellbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_t;

    function automatic int timer_w(input int settle);
        return $clog2(settle) + 1;
    endfunction

endpackage

// File: rtl/asic_cellbist_if.sv
// Control, status and cell-side signals of the cell BIST sequencer.
// master = host plus cell under test, slave = the sequencer.
interface asic_cellbist_if #(
    parameter int N  = 5,
    parameter int EW = 8
);
    logic          start;
    logic          abort;
    logic [N-1:0]  vec;
    logic          z;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] errcnt;
    logic          failvalid;
    logic [N-1:0]  failvec;

    modport master (
        output start, abort, z,
        input  vec, busy, done, pass,
        input  errcnt, failvalid, failvec
    );

    modport slave (
        input  start, abort, z,
        output vec, busy, done, pass,
        output errcnt, failvalid, failvec
    );
endinterface

// File: rtl/asic_cellbist.sv
// Exhaustive self-test sequencer for one combinational library cell:
// walks all 2^N vectors, settles, samples z and compares with TT.
module asic_cellbist
    import asic_cellbist_pkg::*;
#(
    parameter int               N      = 5,
    parameter logic [(1<<N)-1:0] TT    = 32'hEEE00000,
    parameter int               SETTLE = 2,
    parameter int               EW     = 8,
    parameter string            PROP   = "DEFAULT"
) (
    input  logic            clk,
    input  logic            reset,
    asic_cellbist_if.slave  bus
);

    localparam int TW = timer_w(SETTLE);
    localparam logic [TW-1:0] T_LOAD = TW'(SETTLE - 1);

    // Implementation property is carried for netlist flows only.
    if (PROP == "") begin : g_prop_unset
    end

    bist_state_t   state;
    logic [N-1:0]  vec;
    logic [TW-1:0] timer;
    logic          busy;
    logic          done;
    logic [EW-1:0] errcnt;
    logic          failvalid;
    logic [N-1:0]  failvec;
    logic          miss;

    assign miss = (bus.z != TT[vec]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            vec       <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            errcnt    <= '0;
            failvalid <= 1'b0;
            failvec   <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    // abort is meaningless here; start always proceeds
                    if (bus.start) begin
                        vec       <= '0;
                        errcnt    <= '0;
                        failvalid <= 1'b0;
                        failvec   <= '0;
                        timer     <= T_LOAD;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        vec   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (timer == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (bus.abort) begin
                        vec   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        if (miss) begin
                            if (errcnt != '1)
                                errcnt <= errcnt + 1'b1;
                            if (!failvalid) begin
                                failvec   <= vec;
                                failvalid <= 1'b1;
                            end
                        end
                        // last vector is held so results show where it stopped
                        if (vec == '1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            vec   <= vec + 1'b1;
                            timer <= T_LOAD;
                            state <= ST_SETTLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.vec       = vec;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = done & (errcnt == '0);
    assign bus.errcnt    = errcnt;
    assign bus.failvalid = failvalid;
    assign bus.failvec   = failvec;

endmodule

// File: tb/tb_asic_cellbist.sv
// Directed bench for asic_cellbist driving a modelled oa221 cell,
// with run results scoreboarded and checked when done rises.
module tb_asic_cellbist;

    localparam int N  = 5;
    localparam int EW = 4;

    typedef struct packed {
        logic [EW-1:0] err;
        logic          fv;
        logic [N-1:0]  fvec;
        logic          pass;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] zmode = 2'd0;
    int nvec = 0;
    int nerr = 0;
    exp_t q[$];

    asic_cellbist_if #(.N(N), .EW(EW)) bus ();

    asic_cellbist #(
        .N(N), .TT(32'hEEE00000), .SETTLE(2),
        .EW(EW), .PROP("DEFAULT")
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic oa221(input logic [4:0] v);
        return (v[0] | v[1]) & (v[2] | v[3]) & v[4];
    endfunction

    // 0 good cell, 1 stuck-at-0, 2 stuck-at-1
    assign bus.z = (zmode == 2'd2) ? 1'b1 :
                   (zmode == 2'd1) ? 1'b0 : oa221(bus.vec);

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_vec"}, 32'(bus.vec), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    task automatic run(input logic [1:0] mode, input bit with_abort,
                       input int restart_at, input exp_t e);
        int k;
        exp_t got;
        zmode = mode;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = with_abort;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        k = 0;
        while (bus.busy && k <= 200) begin
            if (k == 0) begin
                chk("start_done_drop", 32'(bus.done), 0);
                chk("start_err_clr", 32'(bus.errcnt), 0);
                chk("start_fv_clr", 32'(bus.failvalid), 0);
            end
            chk("walk_vec", 32'(bus.vec), 32'(k / 3));
            bus.start = (k == restart_at);
            k++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("run_len", 32'(k), 96);
        got = q.pop_front();
        chk("done", 32'(bus.done), 1);
        chk("pass", 32'(bus.pass), 32'(got.pass));
        chk("errcnt", 32'(bus.errcnt), 32'(got.err));
        chk("failvalid", 32'(bus.failvalid), 32'(got.fv));
        chk("failvec", 32'(bus.failvec), 32'(got.fvec));
        chk("last_vec", 32'(bus.vec), 31);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #23 reset = 1'b0;
        @(negedge clk);
        chk_idle("rst");
        chk("rst_pass", 32'(bus.pass), 0);
        chk("rst_err", 32'(bus.errcnt), 0);
        chk("rst_fv", 32'(bus.failvalid), 0);
        chk("rst_fvec", 32'(bus.failvec), 0);

        run(2'd0, 1'b0, -1, '{err: 0, fv: 0, fvec: 0, pass: 1});
        run(2'd2, 1'b0, -1, '{err: 15, fv: 1, fvec: 0, pass: 0});
        run(2'd1, 1'b0, -1, '{err: 9, fv: 1, fvec: 21, pass: 0});

        // abort in SETTLE of vector 13 after 13 stuck-at-1 misses
        zmode = 2'd2;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk_idle("abort");
        chk("abort_err", 32'(bus.errcnt), 13);
        chk("abort_fv", 32'(bus.failvalid), 1);
        chk("abort_fvec", 32'(bus.failvec), 0);
        chk("abort_pass", 32'(bus.pass), 0);
        repeat (3) @(negedge clk);
        chk_idle("abort_hold");

        // abort ignored in IDLE, start ignored while busy
        run(2'd0, 1'b1, 50, '{err: 0, fv: 0, fvec: 0, pass: 1});

        // start then start+abort while in SETTLE
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        chk("sa_busy", 32'(bus.busy), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk_idle("sa");

        // asynchronous reset between edges
        zmode = 2'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_err", 32'(bus.errcnt), 6);
        #2 reset = 1'b1;
        #1;
        chk_idle("arst");
        chk("arst_pass", 32'(bus.pass), 0);
        chk("arst_err", 32'(bus.errcnt), 0);
        chk("arst_fv", 32'(bus.failvalid), 0);
        chk("arst_fvec", 32'(bus.failvec), 0);
        #3 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk_idle("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
